adder_flag_stage: RTL and testbench



---
 rtl/adder_flag_stage.sv | 141 ++++++++++++++
 tb/tb_adder_flag_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_flag_stage.sv
// Registered output stage for the 16-bit adder-with-flags datapath, with sticky flags and an overflow counter.
// Latency: an entry accepted into an empty stage is presented one cycle later.
// Backpressure: a 2-entry skid buffer with a registered in_ready that drops only when both entries are full.
module adder_flag_stage #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  z_in,
    input  logic          sign_in,
    input  logic          carry_in,
    input  logic          zero_in,
    input  logic          parity_in,
    input  logic          overflow_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  z_out,
    output logic [4:0]    flags_out,
    output logic [4:0]    sticky_flags,
    input  logic          sticky_clr,
    output logic [CW-1:0] ovf_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [1:0]    state_q,     state_d;
    logic [W-1:0]  main_z_q,    main_z_d;
    logic [4:0]    main_f_q,    main_f_d;
    logic [W-1:0]  skid_z_q,    skid_z_d;
    logic [4:0]    skid_f_q,    skid_f_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [4:0]    sticky_q,    sticky_d;
    logic [CW-1:0] ovf_cnt_q,   ovf_cnt_d;

    logic       accept;
    logic       drain;
    logic [4:0] flags_in;
    logic [4:0] sticky_base;
    logic [CW-1:0] cnt_base;

    // Flags are taken exactly as the adder produced them, packed {sign,carry,zero,parity,overflow}.
    assign flags_in = {sign_in, carry_in, zero_in, parity_in, overflow_in};
    assign accept   = in_valid & in_ready_q;
    assign drain    = out_valid_q & out_ready;

    // Buffer occupancy and data movement; the main register always holds the oldest entry.
    always_comb begin
        state_d  = state_q;
        main_z_d = main_z_q;
        main_f_d = main_f_q;
        skid_z_d = skid_z_q;
        skid_f_d = skid_f_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    main_z_d = z_in;
                    main_f_d = flags_in;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_z_d = z_in;
                    main_f_d = flags_in;
                end else if (accept) begin
                    state_d  = ST_TWO;
                    skid_z_d = z_in;
                    skid_f_d = flags_in;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can change anything.
                if (drain) begin
                    state_d  = ST_ONE;
                    main_z_d = skid_z_q;
                    main_f_d = skid_f_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Sticky flags and overflow counter: a clear acts first, then the same-cycle accept is folded in.
    always_comb begin
        sticky_base = sticky_clr ? 5'd0 : sticky_q;
        cnt_base    = sticky_clr ? '0 : ovf_cnt_q;
        sticky_d    = sticky_base;
        ovf_cnt_d   = cnt_base;
        if (accept) begin
            sticky_d = sticky_base | flags_in;
            if (overflow_in && (cnt_base != CNT_MAX)) begin
                ovf_cnt_d = cnt_base + 1'b1;
            end
        end
    end

    // State and data registers; reset drops any held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_z_q    <= '0;
            main_f_q    <= '0;
            skid_z_q    <= '0;
            skid_f_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sticky_q    <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_z_q    <= main_z_d;
            main_f_q    <= main_f_d;
            skid_z_q    <= skid_z_d;
            skid_f_q    <= skid_f_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign z_out        = main_z_q;
    assign flags_out    = main_f_q;
    assign sticky_flags = sticky_q;
    assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_adder_flag_stage.sv
// Directed bench for adder_flag_stage: reset, single accepts, backpressure, streaming, saturation, async reset.
// Inputs are driven 1ns after the rising edge and outputs are sampled at the same point.
// Expected values are hand-derived or come from a small sticky/counter model kept in the bench.
module tb_adder_flag_stage;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  z_in;
    logic          sign_in, carry_in, zero_in, parity_in, overflow_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  z_out;
    logic [4:0]    flags_out;
    logic [4:0]    sticky_flags;
    logic          sticky_clr;
    logic [CW-1:0] ovf_count;

    int total = 0;
    int bad   = 0;

    int       cnt_exp;
    logic [4:0] sticky_exp;

    always #5 clk = ~clk;

    adder_flag_stage #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .z_in        (z_in),
        .sign_in     (sign_in),
        .carry_in    (carry_in),
        .zero_in     (zero_in),
        .parity_in   (parity_in),
        .overflow_in (overflow_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z_out       (z_out),
        .flags_out   (flags_out),
        .sticky_flags(sticky_flags),
        .sticky_clr  (sticky_clr),
        .ovf_count   (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [W-1:0] z, input logic [4:0] f);
        in_valid = vld;
        z_in     = z;
        {sign_in, carry_in, zero_in, parity_in, overflow_in} = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rz;
        logic [4:0]   rf;

        rst_n = 1'b0;
        out_ready = 1'b0;
        sticky_clr = 1'b0;
        drive(1'b0, '0, 5'd0);
        sticky_exp = 5'd0;
        cnt_exp = 0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_z_out",     {16'd0, z_out},     32'd0);
        chk("rst_flags_out", {27'd0, flags_out}, 32'd0);
        chk("rst_sticky",    {27'd0, sticky_flags}, 32'd0);
        chk("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
        rst_n = 1'b1;

        // Single accept: 7FFF+0001 result
        tick();
        out_ready = 1'b1;
        drive(1'b1, 16'h8000, 5'b10001);
        tick();
        chk("one_out_valid", {31'd0, out_valid}, 32'd1);
        chk("one_z_out",     {16'd0, z_out},     32'h8000);
        chk("one_flags",     {27'd0, flags_out}, 32'h11);
        chk("one_sticky",    {27'd0, sticky_flags}, 32'h11);
        chk("one_ovf_count", {24'd0, ovf_count}, 32'd1);

        // Zero result: FFFF+0001
        drive(1'b1, 16'h0000, 5'b01110);
        tick();
        chk("zero_z_out",  {16'd0, z_out},     32'h0);
        chk("zero_flags",  {27'd0, flags_out}, 32'h0E);
        chk("zero_sticky", {27'd0, sticky_flags}, 32'h1F);
        chk("zero_ovf",    {24'd0, ovf_count}, 32'd1);

        // Drain to empty; outputs hold last values
        drive(1'b0, 16'h0, 5'd0);
        tick();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold_z",    {16'd0, z_out},     32'h0);
        chk("drain_hold_flags",{27'd0, flags_out}, 32'h0E);

        // Backpressure: A, B accepted, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 5'b00000);
        tick();
        chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_a_z_out",    {16'd0, z_out},    32'h1111);
        drive(1'b1, 16'h2222, 5'b00000);
        tick();
        chk("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_b_z_out",    {16'd0, z_out},    32'h1111);
        drive(1'b1, 16'h3333, 5'b00010);
        tick();
        chk("bp_c_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_c_hold_z",   {16'd0, z_out},    32'h1111);
        chk("bp_c_hold_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b",      {16'd0, z_out},    32'h2222);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out_c",      {16'd0, z_out},    32'h3333);
        chk("bp_out_c_flg",  {27'd0, flags_out}, 32'h02);
        chk("bp_out_c_vld",  {31'd0, out_valid}, 32'd1);
        drive(1'b0, 16'h0, 5'd0);
        tick();
        chk("bp_empty",      {31'd0, out_valid}, 32'd0);

        // Clear sticky state with no accept
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("clr_sticky", {27'd0, sticky_flags}, 32'd0);
        chk("clr_ovf",    {24'd0, ovf_count},    32'd0);

        // Streaming 100 random entries at full rate
        sticky_exp = 5'd0;
        cnt_exp = 0;
        for (int i = 0; i < 100; i++) begin
            rz = W'($urandom);
            rf = 5'($urandom);
            drive(1'b1, rz, rf);
            sticky_exp = sticky_exp | rf;
            if (rf[0] && cnt_exp < 255) cnt_exp++;
            tick();
            chk("stream_vld",   {31'd0, out_valid}, 32'd1);
            chk("stream_z",     {16'd0, z_out},     {16'd0, rz});
            chk("stream_flags", {27'd0, flags_out}, {27'd0, rf});
            chk("stream_rdy",   {31'd0, in_ready},  32'd1);
        end
        chk("stream_sticky", {27'd0, sticky_flags}, {27'd0, sticky_exp});
        chk("stream_ovf",    {24'd0, ovf_count},    32'(cnt_exp));

        // Saturation: 300 overflow entries
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'(i), 5'b00001);
            if (cnt_exp < 255) cnt_exp++;
            tick();
        end
        chk("sat_model", 32'(cnt_exp), 32'd255);
        chk("sat_ovf",   {24'd0, ovf_count}, 32'd255);

        // Clear coinciding with an overflow accept
        sticky_clr = 1'b1;
        drive(1'b1, 16'h8000, 5'b10001);
        tick();
        sticky_clr = 1'b0;
        chk("clracc_ovf",    {24'd0, ovf_count},    32'd1);
        chk("clracc_sticky", {27'd0, sticky_flags}, 32'h11);
        chk("clracc_z",      {16'd0, z_out},        32'h8000);

        // Fill to TWO, then async reset mid-cycle
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 5'b00000);
        tick();
        drive(1'b1, 16'hBBBB, 5'b00000);
        tick();
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 16'h0, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("arst_z_out",     {16'd0, z_out},     32'h0);
        chk("arst_flags",     {27'd0, flags_out}, 32'h0);
        chk("arst_sticky",    {27'd0, sticky_flags}, 32'h0);
        chk("arst_ovf",       {24'd0, ovf_count}, 32'h0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("post_rst_rdy", {31'd0, in_ready},  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
